// File: rtl/sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// sram_req_arbiter
//   Shares one SRAM-like memory port between instruction fetch (inst_*) and
//   the load/store path (data_*). The address phase is arbitrated and passed
//   straight through to the memory port. A grant that the port does not take
//   at once is locked until mem_addr_ok. An in-order ID FIFO records which
//   requester issued each accepted transaction, so that every response goes
//   back to its issuer.
//
//   Optional feature macro:
//     SRAM_ARB_RR_EN  - defined: round-robin between inst and data when both
//                       request in IDLE (the first grant goes to data).
//                       undefined: fixed data-over-inst priority.
// -----------------------------------------------------------------------------
module sram_req_arbiter #(
    parameter int MAX_OUTSTANDING = 2   // ID FIFO depth, power of 2, >= 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        arb_err
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    // Requester IDs as stored in the FIFO and in the grant lock
    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                     state;
    logic                       lock_id;      // requester owning a held grant

    logic [MAX_OUTSTANDING-1:0] id_mem;       // one ID bit per FIFO slot
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;

    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       any_req;
    logic                       grant_id;     // requester driving the port now
    logic                       push;
    logic                       pop;
    logic                       head_id;

`ifdef SRAM_ARB_RR_EN
    logic                       rr_ptr;       // 1 = data wins the next tie
`endif

    assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign any_req    = inst_req | data_req;
    assign head_id    = id_mem[rd_ptr];

    // Decide whether the port is requested this cycle and who owns it
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
        mem_req  = 1'b0;
        grant_id = ID_INST;
        if (resetn) begin
            if (state == HOLD) begin
                // The locked requester keeps the port; late arrivals wait.
                mem_req  = 1'b1;
                grant_id = lock_id;
            end else begin
                // The full test uses the pre-pop count, so a response in this
                // cycle never frees a slot for a new request in the same cycle.
                mem_req = any_req & ~fifo_full;
`ifdef SRAM_ARB_RR_EN
                if (inst_req && data_req)
                    grant_id = rr_ptr;
                else
                    grant_id = data_req ? ID_DATA : ID_INST;
`else
                grant_id = data_req ? ID_DATA : ID_INST;
`endif
            end
        end
    end

    // Put the owning requester's fields on the port (inst is a word read)
    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'd2;
        mem_wstrb = 4'h0;
        mem_addr  = inst_addr;
        mem_wdata = 32'h0;
        if (grant_id == ID_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end
    end

    assign push = mem_req & mem_addr_ok;
    assign pop  = mem_data_ok & ~fifo_empty;

    // A request is accepted only for the requester currently owning the port
    assign inst_addr_ok = push & (grant_id == ID_INST);
    assign data_addr_ok = push & (grant_id == ID_DATA);

    // The FIFO head steers each response; the read data itself is unqualified
    assign inst_data_ok = pop & (head_id == ID_INST);
    assign data_data_ok = pop & (head_id == ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // Grant FSM: lock a grant the port did not take, release it on acceptance
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values regardless of statement order.
        if (!resetn) begin
            state   <= IDLE;
            lock_id <= ID_INST;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req && !mem_addr_ok) begin
                        lock_id <= grant_id;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (mem_addr_ok)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ID storage: record the issuer of each accepted request
    always_ff @(posedge clk) begin
        // NOTE: the ID array has no reset; count gates every read, so stale entries are never observed.
        if (push)
            id_mem[wr_ptr] <= grant_id;
    end

    // Sticky error: a response arrived with nothing outstanding
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            arb_err <= 1'b0;
        else if (mem_data_ok && fifo_empty)
            arb_err <= 1'b1;
    end

`ifdef SRAM_ARB_RR_EN
    // Round-robin pointer: after each accepted grant, favour the other requester
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rr_ptr <= ID_DATA;
        else if (push)
            rr_ptr <= ~grant_id;
    end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_req_arbiter
//   Directed self-checking bench for sram_req_arbiter with MAX_OUTSTANDING = 2.
//   Inputs change on the falling edge; outputs are checked 1 ns later, well
//   away from the rising edge. Honours SRAM_ARB_RR_EN for the tie sequence.
// -----------------------------------------------------------------------------
module tb_sram_req_arbiter;

    localparam logic [31:0] IA = 32'h0000_1000;
    localparam logic [31:0] DA = 32'h8000_0040;
    localparam logic [31:0] DW = 32'hCAFE_F00D;
    localparam logic [31:0] R1 = 32'h1111_2222;
    localparam logic [31:0] R2 = 32'h3333_4444;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        arb_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_req_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .arb_err(arb_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic quiet_inputs();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd0;
        data_wstrb  = 4'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    logic exp_g [4];

    initial begin
        inst_addr  = IA;
        data_addr  = DA;
        data_wdata = DW;
        quiet_inputs();

        // ---- Reset with everything asserted ----
        resetn = 1'b0;
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        next_cycle(); #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_inst_addr_ok", inst_addr_ok, 0);
        check("rst_data_addr_ok", data_addr_ok, 0);
        check("rst_inst_data_ok", inst_data_ok, 0);
        check("rst_data_data_ok", data_data_ok, 0);
        check("rst_arb_err", arb_err, 0);
        quiet_inputs();
        next_cycle(); resetn = 1'b1;
        next_cycle();

        // ---- Both request: data first, then inst; responses in order ----
        inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1;
        data_size = 2'd2; data_wstrb = 4'hf; mem_addr_ok = 1'b1;
        #1;
        check("both_mem_req", mem_req, 1);
        check("both_mem_addr", mem_addr, DA);
        check("both_data_addr_ok", data_addr_ok, 1);
        check("both_inst_addr_ok", inst_addr_ok, 0);
        check("both_mem_wr", mem_wr, 1);
        check("both_mem_wstrb", mem_wstrb, 4'hf);
        check("both_mem_wdata", mem_wdata, DW);
        next_cycle();
        data_req = 1'b0; data_wr = 1'b0;
        #1;
        check("inst_mem_addr", mem_addr, IA);
        check("inst_addr_ok", inst_addr_ok, 1);
        check("inst_mem_wr", mem_wr, 0);
        check("inst_mem_size", mem_size, 2);
        check("inst_mem_wstrb", mem_wstrb, 0);
        check("inst_mem_wdata", mem_wdata, 0);
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = R1;
        #1;
        check("full_mem_req", mem_req, 0);
        check("resp1_data_ok", data_data_ok, 1);
        check("resp1_inst_ok", inst_data_ok, 0);
        check("resp1_rdata", data_rdata, R1);
        next_cycle();
        mem_rdata = R2;
        #1;
        check("resp2_inst_ok", inst_data_ok, 1);
        check("resp2_data_ok", data_data_ok, 0);
        check("resp2_rdata", inst_rdata, R2);
        next_cycle();
        mem_data_ok = 1'b0;

        // ---- Back-to-back ties (push+pop keeps a slot free) ----
`ifdef SRAM_ARB_RR_EN
        exp_g[0] = 1'b1; exp_g[1] = 1'b0; exp_g[2] = 1'b1; exp_g[3] = 1'b0;
`else
        exp_g[0] = 1'b1; exp_g[1] = 1'b1; exp_g[2] = 1'b1; exp_g[3] = 1'b1;
`endif
        for (int i = 0; i < 4; i++) begin
            inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
            mem_data_ok = (i > 0);
            #1;
            check($sformatf("tie%0d_data_addr_ok", i), data_addr_ok, exp_g[i]);
            check($sformatf("tie%0d_inst_addr_ok", i), inst_addr_ok, !exp_g[i]);
            check($sformatf("tie%0d_mem_addr", i), mem_addr, exp_g[i] ? DA : IA);
            if (i > 0)
                check($sformatf("tie%0d_data_data_ok", i), data_data_ok, exp_g[i-1]);
            next_cycle();
        end
        quiet_inputs();
        mem_data_ok = 1'b1;
        #1;
        check("tie_drain_data_ok", data_data_ok, exp_g[3]);
        check("tie_drain_inst_ok", inst_data_ok, !exp_g[3]);
        next_cycle();
        mem_data_ok = 1'b0;

        // ---- Held inst grant ignores a later data request ----
        inst_req = 1'b1;
        #1;
        check("hold1_mem_addr", mem_addr, IA);
        check("hold1_inst_addr_ok", inst_addr_ok, 0);
        next_cycle();
        data_req = 1'b1;
        #1;
        check("hold2_mem_req", mem_req, 1);
        check("hold2_mem_addr", mem_addr, IA);
        check("hold2_data_addr_ok", data_addr_ok, 0);
        next_cycle();
        #1;
        check("hold3_mem_addr", mem_addr, IA);
        next_cycle();
        mem_addr_ok = 1'b1;
        #1;
        check("hold4_inst_addr_ok", inst_addr_ok, 1);
        check("hold4_data_addr_ok", data_addr_ok, 0);
        next_cycle();
        inst_req = 1'b0;
        #1;
        check("after_hold_data_addr_ok", data_addr_ok, 1);
        check("after_hold_mem_addr", mem_addr, DA);
        next_cycle();

        // ---- FIFO full: blocked request, pop does not allow a same-cycle push ----
        data_req = 1'b0; inst_req = 1'b1; mem_addr_ok = 1'b1;
        #1;
        check("full_blk_mem_req", mem_req, 0);
        check("full_blk_inst_addr_ok", inst_addr_ok, 0);
        next_cycle();
        mem_data_ok = 1'b1;
        #1;
        check("full_pop_mem_req", mem_req, 0);
        check("full_pop_inst_addr_ok", inst_addr_ok, 0);
        check("full_pop_inst_data_ok", inst_data_ok, 1);
        next_cycle();
        mem_data_ok = 1'b0;
        #1;
        check("after_pop_mem_req", mem_req, 1);
        check("after_pop_inst_addr_ok", inst_addr_ok, 1);
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        #1;
        check("drain1_data_ok", data_data_ok, 1);
        next_cycle();
        #1;
        check("drain2_inst_ok", inst_data_ok, 1);
        next_cycle();
        mem_data_ok = 1'b0;

        // ---- Push and pop together at count 1 for 8 cycles ----
        data_req = 1'b1; mem_addr_ok = 1'b1;
        next_cycle();
        for (int k = 0; k < 8; k++) begin
            inst_req = (k % 2 == 0);
            data_req = (k % 2 == 1);
            mem_data_ok = 1'b1;
            #1;
            check($sformatf("pp%0d_addr_ok", k), inst_addr_ok | data_addr_ok, 1);
            check($sformatf("pp%0d_grant_data", k), data_addr_ok, (k % 2 == 1));
            // previous issuer: data before k=0, then alternating inst/data
            check($sformatf("pp%0d_resp_data", k), data_data_ok, (k == 0) || (k % 2 == 0));
            check($sformatf("pp%0d_resp_inst", k), inst_data_ok, (k != 0) && (k % 2 == 1));
            next_cycle();
        end
        quiet_inputs();
        mem_data_ok = 1'b1;
        #1;
        check("pp_drain_data_ok", data_data_ok, 1);
        next_cycle();

        // ---- Response with empty FIFO: sticky error ----
        #1;
        check("empty_inst_data_ok", inst_data_ok, 0);
        check("empty_data_data_ok", data_data_ok, 0);
        check("empty_arb_err_pre", arb_err, 0);
        next_cycle();
        #1;
        check("empty_arb_err_set", arb_err, 1);
        mem_data_ok = 1'b0;
        next_cycle();
        #1;
        check("empty_arb_err_sticky", arb_err, 1);

        // ---- Reset discards an in-flight ID and clears the error ----
        inst_req = 1'b1; mem_addr_ok = 1'b1;
        next_cycle();
        quiet_inputs();
        resetn = 1'b0;
        #1;
        check("rst2_arb_err", arb_err, 0);
        check("rst2_mem_req", mem_req, 0);
        next_cycle(); resetn = 1'b1;
        next_cycle();
        mem_data_ok = 1'b1;
        #1;
        check("discard_inst_data_ok", inst_data_ok, 0);
        next_cycle();
        #1;
        check("discard_arb_err", arb_err, 1);
        mem_data_ok = 1'b0;
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
